// File: rtl/f_pc_unit.sv
// Fetch-stage PC register and next-PC select for the 5-stage MIPS pipeline.
// Branch/jump decisions made in D redirect the next fetch (delay slot kept).
module f_pc_unit #(
   parameter logic [31:0] RESET_PC   = 32'h0000_3000,
   parameter logic [31:0] TEXT_BASE  = 32'h0000_3000,
   parameter logic [31:0] TEXT_LIMIT = 32'h0000_6ffc
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic [31:0] D_pc,
   input  logic [2:0]  D_npc_op,
   input  logic [15:0] D_imm16,
   input  logic [25:0] D_imm26,
   input  logic [31:0] D_rs_Data,
   input  logic        D_CMP_out,
   output logic [31:0] F_pc,
   output logic [31:0] D_link_pc,
   output logic        D_redirect,
   output logic        F_exc_adel
);

   localparam logic [2:0] OP_SEQ = 3'd0;
   localparam logic [2:0] OP_BEQ = 3'd1;
   localparam logic [2:0] OP_BNE = 3'd2;
   localparam logic [2:0] OP_J   = 3'd3;
   localparam logic [2:0] OP_JR  = 3'd4;

   logic [31:0] r_pc;
   logic [31:0] w_br_tgt;
   logic [31:0] w_j_tgt;
   logic [31:0] w_target;
   logic        w_redirect;

   assign w_br_tgt = D_pc + 32'd4
                   + {{14{D_imm16[15]}}, D_imm16, 2'b00};
   assign w_j_tgt  = {D_pc[31:28], D_imm26, 2'b00};

   always_comb begin
      w_redirect = 1'b0;
      w_target   = w_br_tgt;
      case (D_npc_op)
         OP_BEQ: w_redirect = D_CMP_out;
         OP_BNE: w_redirect = ~D_CMP_out;
         OP_J: begin
            w_redirect = 1'b1;
            w_target   = w_j_tgt;
         end
         OP_JR: begin
            w_redirect = 1'b1;
            w_target   = D_rs_Data;
         end
         OP_SEQ:  w_redirect = 1'b0;
         default: w_redirect = 1'b0;
      endcase
   end

   // A stalled D keeps its redirect pending until the stall drops.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_pc <= RESET_PC;
      end else if (!stall) begin
         r_pc <= w_redirect ? w_target : r_pc + 32'd4;
      end
   end

   assign F_pc       = r_pc;
   assign D_link_pc  = D_pc + 32'd8;
   assign D_redirect = w_redirect;
   assign F_exc_adel = (r_pc[1:0] != 2'b00)
                     | (r_pc < TEXT_BASE)
                     | (r_pc > TEXT_LIMIT);

endmodule

// File: tb/tb_f_pc_unit.sv
// Directed vector bench for f_pc_unit: table of per-edge vectors
// plus hand-written stall and asynchronous-reset sequences.
module tb_f_pc_unit;

   typedef struct {
      logic        stall;
      logic [2:0]  op;
      logic [31:0] dpc;
      logic [15:0] imm16;
      logic [25:0] imm26;
      logic [31:0] rs;
      logic        cmp;
      logic        e_redir;
      logic [31:0] e_link;
      logic [31:0] e_pc;
      logic        e_adel;
   } vec_t;

   logic        clk;
   logic        reset;
   logic        stall;
   logic [31:0] D_pc;
   logic [2:0]  D_npc_op;
   logic [15:0] D_imm16;
   logic [25:0] D_imm26;
   logic [31:0] D_rs_Data;
   logic        D_CMP_out;
   logic [31:0] F_pc;
   logic [31:0] D_link_pc;
   logic        D_redirect;
   logic        F_exc_adel;

   int checks;
   int failures;
   vec_t vq[$];

   f_pc_unit dut (
      .clk        (clk),
      .reset      (reset),
      .stall      (stall),
      .D_pc       (D_pc),
      .D_npc_op   (D_npc_op),
      .D_imm16    (D_imm16),
      .D_imm26    (D_imm26),
      .D_rs_Data  (D_rs_Data),
      .D_CMP_out  (D_CMP_out),
      .F_pc       (F_pc),
      .D_link_pc  (D_link_pc),
      .D_redirect (D_redirect),
      .F_exc_adel (F_exc_adel)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [31:0] act,
                        input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic add(input logic st, input logic [2:0] op,
                      input logic [31:0] dpc, input logic [15:0] i16,
                      input logic [25:0] i26, input logic [31:0] rs,
                      input logic cmp, input logic er,
                      input logic [31:0] el, input logic [31:0] ep,
                      input logic ea);
      vec_t v;
      v.stall = st; v.op = op; v.dpc = dpc; v.imm16 = i16;
      v.imm26 = i26; v.rs = rs; v.cmp = cmp; v.e_redir = er;
      v.e_link = el; v.e_pc = ep; v.e_adel = ea;
      vq.push_back(v);
   endtask

   task automatic drive(input logic st, input logic [2:0] op,
                        input logic [31:0] dpc, input logic [15:0] i16,
                        input logic [25:0] i26, input logic [31:0] rs,
                        input logic cmp);
      stall = st; D_npc_op = op; D_pc = dpc; D_imm16 = i16;
      D_imm26 = i26; D_rs_Data = rs; D_CMP_out = cmp;
   endtask

   initial begin
      checks = 0;
      failures = 0;
      reset = 1'b0;
      drive(1'b0, 3'd0, 32'h0, 16'h0, 26'h0, 32'h0, 1'b0);

      //  st op  dpc           imm16    imm26     rs            c  r  link          next pc       adel
      add(0, 0, 32'h0000_0000, 16'h0,    26'h0,    32'h0,        0, 0, 32'h0000_0008, 32'h0000_3004, 0);
      add(0, 0, 32'h0000_3000, 16'h0,    26'h0,    32'h0,        0, 0, 32'h0000_3008, 32'h0000_3008, 0);
      add(0, 1, 32'h0000_3010, 16'hFFFC, 26'h0,    32'h0,        1, 1, 32'h0000_3018, 32'h0000_3004, 0);
      add(0, 1, 32'h0000_3010, 16'hFFFC, 26'h0,    32'h0,        0, 0, 32'h0000_3018, 32'h0000_3008, 0);
      add(0, 2, 32'h0000_3010, 16'hFFFC, 26'h0,    32'h0,        0, 1, 32'h0000_3018, 32'h0000_3004, 0);
      add(0, 2, 32'h0000_3010, 16'hFFFC, 26'h0,    32'h0,        1, 0, 32'h0000_3018, 32'h0000_3008, 0);
      add(0, 3, 32'h3000_3000, 16'h0,    26'h0C10, 32'h0,        0, 1, 32'h3000_3008, 32'h3000_3040, 1);
      add(0, 4, 32'h0000_3000, 16'h0,    26'h0,    32'h0000_3002, 0, 1, 32'h0000_3008, 32'h0000_3002, 1);
      add(0, 0, 32'h0000_3004, 16'h0,    26'h0,    32'h0,        0, 0, 32'h0000_300C, 32'h0000_3006, 1);
      add(0, 5, 32'h0000_3008, 16'h0,    26'h0,    32'h0000_4000, 1, 0, 32'h0000_3010, 32'h0000_300A, 1);
      add(0, 7, 32'h0000_3008, 16'h0,    26'h0,    32'h0000_4000, 0, 0, 32'h0000_3010, 32'h0000_300E, 1);
      add(0, 4, 32'h0000_3008, 16'h0,    26'h0,    32'h0000_6FFC, 0, 1, 32'h0000_3010, 32'h0000_6FFC, 0);
      add(0, 0, 32'h0000_3008, 16'h0,    26'h0,    32'h0,        0, 0, 32'h0000_3010, 32'h0000_7000, 1);
      add(0, 4, 32'h0000_3008, 16'h0,    26'h0,    32'h0000_2FFC, 0, 1, 32'h0000_3010, 32'h0000_2FFC, 1);
      add(0, 4, 32'hFFFF_FFFC, 16'h0,    26'h0,    32'hFFFF_FFFC, 0, 1, 32'h0000_0004, 32'hFFFF_FFFC, 1);
      add(0, 0, 32'hFFFF_FFF8, 16'h0,    26'h0,    32'h0,        0, 0, 32'h0000_0000, 32'h0000_0000, 1);
      add(1, 3, 32'h3000_3000, 16'h0,    26'h0C10, 32'h0,        0, 1, 32'h3000_3008, 32'h0000_0000, 1);
      add(0, 4, 32'h0000_3000, 16'h0,    26'h0,    32'h0000_3000, 0, 1, 32'h0000_3008, 32'h0000_3000, 0);
      add(0, 1, 32'h0000_3000, 16'h7FFF, 26'h0,    32'h0,        1, 1, 32'h0000_3008, 32'h0002_3000, 1);
      add(0, 1, 32'h0000_3100, 16'h8000, 26'h0,    32'h0,        1, 1, 32'h0000_3108, 32'hFFFE_3104, 1);

      // Reset state, across a clock edge.
      @(posedge clk); #1;
      check("reset_pc", F_pc, 32'h0000_3000);
      check("reset_adel", {31'h0, F_exc_adel}, 32'h0);
      @(negedge clk);
      reset = 1'b1;

      for (int i = 0; i < vq.size(); i++) begin
         drive(vq[i].stall, vq[i].op, vq[i].dpc, vq[i].imm16,
               vq[i].imm26, vq[i].rs, vq[i].cmp);
         #1;
         check($sformatf("v%0d_redir", i), {31'h0, D_redirect},
               {31'h0, vq[i].e_redir});
         check($sformatf("v%0d_link", i), D_link_pc, vq[i].e_link);
         @(posedge clk); #1;
         check($sformatf("v%0d_pc", i), F_pc, vq[i].e_pc);
         check($sformatf("v%0d_adel", i), {31'h0, F_exc_adel},
               {31'h0, vq[i].e_adel});
         @(negedge clk);
      end

      // Stalled taken branch: redirect waits for the release edge.
      drive(1'b0, 3'd4, 32'h0000_3000, 16'h0, 26'h0, 32'h0000_3050, 1'b0);
      @(posedge clk); #1;
      check("pre_stall_pc", F_pc, 32'h0000_3050);
      @(negedge clk);
      drive(1'b1, 3'd1, 32'h0000_3000, 16'h003F, 26'h0, 32'h0, 1'b1);
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #1;
         check($sformatf("stall%0d_pc", k), F_pc, 32'h0000_3050);
         @(negedge clk);
      end
      stall = 1'b0;
      @(posedge clk); #1;
      check("stall_release_pc", F_pc, 32'h0000_3100);

      // Asynchronous reset between edges with a stalled redirect pending.
      @(negedge clk);
      drive(1'b1, 3'd4, 32'h0000_3000, 16'h0, 26'h0, 32'h0000_5000, 1'b0);
      #2;
      reset = 1'b0;
      #1;
      check("async_reset_pc", F_pc, 32'h0000_3000);
      stall = 1'b0;
      @(posedge clk); #1;
      check("reset_hold_pc", F_pc, 32'h0000_3000);
      @(negedge clk);
      reset = 1'b1;
      stall = 1'b1;
      @(posedge clk); #1;
      check("release_stall_pc", F_pc, 32'h0000_3000);
      @(negedge clk);
      drive(1'b0, 3'd4, 32'h0000_3000, 16'h0, 26'h0, 32'h0000_7000, 1'b0);
      @(posedge clk); #1;
      check("jr7000_pc", F_pc, 32'h0000_7000);
      check("jr7000_adel", {31'h0, F_exc_adel}, 32'h1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/f_pc_unit.md
Name: f_pc_unit

Overview:
Fetch-stage program counter register and next-PC selector for the 5-stage MIPS pipeline. It consumes the D-stage branch decision from the D-stage register comparator, together with the decoded D-stage control-flow op, immediates and forwarded rs value, and produces the PC of the instruction being fetched. Branch delay slots are architectural: redirects computed in D take effect on the next fetch with no flush. It also flags fetch address exceptions for the exception stage.

Parameters:
RESET_PC, 32'h0000_3000, PC loaded on reset.
TEXT_BASE, 32'h0000_3000, lowest legal instruction address.
TEXT_LIMIT, 32'h0000_6ffc, highest legal instruction address (inclusive).

Ports:
clk  input  1  system clock; all state updates on rising edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
stall  input  1  from hazard unit; 1 holds F_pc
D_pc  input  32  PC of the instruction currently in D
D_npc_op  input  3  0=SEQ, 1=BEQ, 2=BNE, 3=J (j/jal), 4=JR (jr/jalr), 5..7 reserved
D_imm16  input  16  branch offset field of the D instruction
D_imm26  input  26  jump index field of the D instruction
D_rs_Data  input  32  forwarded rs value for JR
D_CMP_out  input  1  1 when forwarded rs == rt in D
F_pc  output  32  current fetch address
D_link_pc  output  32  D_pc + 8, link value for jal/jalr
D_redirect  output  1  1 when the D instruction redirects fetch this cycle
F_exc_adel  output  1  fetch address error for F_pc

Behaviour:
- Reset (reset==0, asynchronous): F_pc <= RESET_PC immediately, held while reset is low. D_redirect and F_exc_adel follow combinationally from inputs/state; with reset asserted and RESET_PC legal, F_exc_adel=0.
- State: the 32-bit F_pc register only. All other outputs are combinational from F_pc and D inputs; zero latency.
- Redirect decode (combinational):
  BEQ taken iff D_CMP_out==1; BNE taken iff D_CMP_out==0; J and JR always redirect; SEQ and reserved codes 5..7 never redirect.
- Targets (mod 2^32; carries beyond bit 31 are discarded):
  branch = D_pc + 4 + (sign_extend(D_imm16) << 2);
  jump = {D_pc[31:28], D_imm26, 2'b00} (region taken from D_pc, not D_pc+4);
  jr = D_rs_Data, unmodified (no alignment masking).
- Next-PC priority on each rising edge with reset high:
  1. stall==1: F_pc holds, even if D_redirect==1. The D instruction is also held by the hazard unit, so the redirect is taken on the first non-stalled edge.
  2. D_redirect==1: F_pc <= selected target.
  3. Otherwise: F_pc <= F_pc + 4. 0xFFFF_FFFC wraps to 0x0000_0000.
- Delay slot: the instruction fetched in the same cycle the branch is in D (D_pc+4) always executes. No kill or flush output exists.
- D_link_pc = D_pc + 8 for every op, mod 2^32.
- F_exc_adel = (F_pc[1:0] != 0) or (F_pc < TEXT_BASE) or (F_pc > TEXT_LIMIT), using unsigned compares.
  - The PC is still advanced or redirected normally when F_exc_adel is set. Squashing is the exception unit's job.
  - A misaligned JR target is loaded as-is and then flagged.
- Reset asserted mid-stall or mid-redirect: reset wins, and F_pc = RESET_PC on assertion.
- Reset release: the first edge with reset high applies the normal priority rules.

Test Plan:
- Reset low, then release with stall=0 and op=SEQ -> F_pc 0x3000 during reset, then 0x3004, 0x3008 on successive edges, F_exc_adel=0 throughout.
- D_pc=0x3010, op=BEQ, imm16=0xFFFC, CMP=1 -> D_redirect=1, next F_pc=0x3004. With CMP=0 -> D_redirect=0, next F_pc=F_pc+4. Op=BNE with CMP=0 -> F_pc=0x3004.
- D_pc=0x3000_3000, op=J, imm26=0x0000C10 -> next F_pc=0x3000_3040. D_link_pc=0x3000_3008.
- op=JR, D_rs_Data=0x0000_3002 -> F_pc=0x3002, F_exc_adel=1. Next edge with SEQ -> F_pc=0x3006, F_exc_adel=1.
- BEQ taken (target 0x3100) with stall=1 for 3 cycles, then stall=0 -> F_pc constant for 3 edges, then 0x3100 on the release edge.
- Reset asserted asynchronously between edges while F_pc=0x3100 -> F_pc=0x3000 without a clock edge. Separately, op=JR with rs=0x7000 -> F_exc_adel=1.
